// File: rtl/downstream_order_tracker.sv
// downstream_order_tracker: per-client cancelled-order totals held in a
// single-port synchronous RAM. Each request is serialised through
// READ -> WRITE, so the next request always sees the previous write.
// Optional feature: define DOWNSTREAM_DEDUP_EN to drop back-to-back
// duplicate requests and count them in dup_count.
module downstream_order_tracker #(
  parameter int CLIENT_W = 5,
  parameter int AMOUNT_W = 16,
  parameter int ACC_W    = 16,
  parameter int ACC_MODE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CLIENT_W-1:0] client_id,
  input  logic [AMOUNT_W-1:0] amount,
  output logic                out_valid,
  output logic [CLIENT_W-1:0] out_client_id,
  output logic [ACC_W-1:0]    cancelled_orders,
  output logic                busy,
  output logic [15:0]         dup_count
);

  localparam int DEPTH = 1 << CLIENT_W;

  typedef enum logic [1:0] {CLEAR, IDLE, READ, WRITE} state_t;

  state_t              state;
  logic [CLIENT_W-1:0] clr_ptr;
  logic [CLIENT_W-1:0] req_id;
  logic [AMOUNT_W-1:0] req_amt;

  logic [ACC_W-1:0]    mem [DEPTH];
  logic [ACC_W-1:0]    rd_data;
  logic                ram_we;
  logic [CLIENT_W-1:0] ram_addr;
  logic [ACC_W-1:0]    ram_wdata;

  logic [ACC_W:0]      sum;
  logic [ACC_W-1:0]    new_total;
  logic                accept;
  logic                is_dup;

  assign accept = in_valid && in_ready;

`ifdef DOWNSTREAM_DEDUP_EN
  logic                hist_valid;
  logic [CLIENT_W-1:0] hist_id;
  logic [AMOUNT_W-1:0] hist_amt;

  assign is_dup = hist_valid && (client_id == hist_id) && (amount == hist_amt);

  // Remember the last processed request and count saturating drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_valid <= 1'b0;
      hist_id    <= '0;
      hist_amt   <= '0;
      dup_count  <= '0;
    end else if (accept) begin
      if (is_dup) begin
        if (dup_count != 16'hFFFF) dup_count <= dup_count + 16'd1;
      end else begin
        hist_valid <= 1'b1;
        hist_id    <= client_id;
        hist_amt   <= amount;
      end
    end
  end
`else
  assign is_dup    = 1'b0;
  assign dup_count = '0;
`endif

  // New total from the RAM word fetched in READ; saturates instead of wrapping.
  always_comb begin
    sum = {1'b0, rd_data} + (ACC_W+1)'(req_amt);
    if (ACC_MODE == 0)
      new_total = ACC_W'(req_amt);
    else if (sum[ACC_W])
      new_total = '1;
    else
      new_total = sum[ACC_W-1:0];
  end

  // One RAM access per cycle: clear sweep, request read, or result write.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = req_id;
    ram_wdata = new_total;
    case (state)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_ptr;
        ram_wdata = '0;
      end
      WRITE:   ram_we = 1'b1;
      default: ;
    endcase
  end

  // Single-port RAM with one-cycle registered read.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rd_data <= mem[ram_addr];
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= CLEAR;
      clr_ptr          <= '0;
      req_id           <= '0;
      req_amt          <= '0;
      in_ready         <= 1'b0;
      busy             <= 1'b1;
      out_valid        <= 1'b0;
      out_client_id    <= '0;
      cancelled_orders <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == {CLIENT_W{1'b1}}) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        IDLE: begin
          if (accept && !is_dup) begin
            req_id   <= client_id;
            req_amt  <= amount;
            state    <= READ;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        READ: state <= WRITE;
        WRITE: begin
          out_valid        <= 1'b1;
          out_client_id    <= req_id;
          cancelled_orders <= new_total;
          state            <= IDLE;
          in_ready         <= 1'b1;
          busy             <= 1'b0;
        end
        default: begin
          state    <= CLEAR;
          clr_ptr  <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
      endcase
    end
  end

endmodule
